// File: rtl/serial_add_pkg.sv
// serial_add_pkg
//   Shared definitions for the byte-serial add scheduler.
//   NUM_REQ : number of requesters sharing the adder
//   BYTE_W  : width of one serial slice
//   state_t : scheduler FSM state encoding (IDLE / RUN / DONE)
package serial_add_pkg;

    localparam int NUM_REQ = 2;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/prefix_adder_8b.sv
// prefix_adder_8b
//   Combinational 8-bit adder with carry in/out, built from bitwise
//   generate/propagate pre-processing followed by a Kogge-Stone prefix tree.
// Ports
//   a_i, b_i : 8-bit operands
//   cin_i    : carry in
//   sum_o    : 8-bit sum
//   cout_o   : carry out of bit 7
module prefix_adder_8b
    import serial_add_pkg::*;
(
    input  logic [BYTE_W-1:0] a_i,
    input  logic [BYTE_W-1:0] b_i,
    input  logic              cin_i,
    output logic [BYTE_W-1:0] sum_o,
    output logic              cout_o
);

    // Returns the carry into every bit position: bit 0 is the carry in,
    // bit 8 is the carry out. The carry in is folded in as a generate at
    // position 0 so the prefix tree produces every carry directly.
    function automatic logic [8:0] prefix_carries(
        input logic [7:0] g,
        input logic [7:0] p,
        input logic       c0
    );
        logic [8:0] gg;
        logic [8:0] pp;
        gg = {g, c0};
        pp = {p, 1'b0};
        for (int d = 1; d < 9; d = d * 2) begin
            // Descending order keeps gg[i-d]/pp[i-d] at the previous level.
            for (int i = 8; i >= d; i--) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        return gg;
    endfunction

    logic [7:0] gen;
    logic [7:0] prop;
    logic [8:0] carries;

    assign gen     = a_i & b_i;
    assign prop    = a_i ^ b_i;
    assign carries = prefix_carries(gen, prop, cin_i);
    assign sum_o   = prop ^ carries[7:0];
    assign cout_o  = carries[8];

endmodule

// File: rtl/serial_add_scheduler.sv
// serial_add_scheduler
//   Two requesters share one 8-bit adder; a W-bit add (W = 8*NUM_BYTES) is
//   computed byte-serially, least-significant byte first, one byte per cycle.
//
//   Handshakes: a transfer happens on any rising edge where valid and ready
//   are both high. Request side: req_ready_o is asserted only in IDLE, one-hot
//   to the round-robin winner, and never depends on it being accepted later.
//   Response side: rsp_valid_o stays high with stable data until rsp_ready_i.
//
// Ports
//   clk_i, rst_i          : clock, synchronous active-high reset
//   req_valid_i/ready_o   : per-requester request handshake
//   op_a0_i, op_b0_i      : requester 0 operands
//   op_a1_i, op_b1_i      : requester 1 operands
//   carry_i               : per-requester carry-in
//   rsp_valid_o/ready_i   : response handshake
//   rsp_id_o              : requester owning the result
//   sum_o, carry_o        : W-bit sum and final carry-out
//   busy_o                : high whenever the FSM is not IDLE
//   dbg_state_o           : current FSM state
module serial_add_scheduler
    import serial_add_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [8*NUM_BYTES-1:0]   op_a0_i,
    input  logic [8*NUM_BYTES-1:0]   op_b0_i,
    input  logic [8*NUM_BYTES-1:0]   op_a1_i,
    input  logic [8*NUM_BYTES-1:0]   op_b1_i,
    input  logic [NUM_REQ-1:0]       carry_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic                     rsp_id_o,
    output logic [8*NUM_BYTES-1:0]   sum_o,
    output logic                     carry_o,
    output logic                     busy_o,
    output state_t                   dbg_state_o
);

    localparam int         W    = 8 * NUM_BYTES;
    localparam logic [2:0] LAST = 3'(NUM_BYTES - 1);

    state_t            state_q, state_d;
    logic              rr_q;
    logic [2:0]        cnt_q;
    logic [W-1:0]      a_q, b_q;
    logic              cin_q;
    logic              id_q;
    logic              slice_carry_q;
    logic [W-1:0]      sum_q;
    logic              cout_q;

    logic              winner;
    logic [NUM_REQ-1:0] ready;
    logic              slice_cin;
    logic [BYTE_W-1:0] slice_sum;
    logic              slice_cout;

    // Single valid requester wins outright; on contention rr picks.
    assign winner = (req_valid_i == 2'b11) ? rr_q : req_valid_i[1];

    always_comb begin
        state_d = state_q;
        ready   = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    ready   = winner ? 2'b10 : 2'b01;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands are shifted right each RUN cycle, so the active slice is
    // always the low byte; the first slice takes the requester's carry-in.
    assign slice_cin = (cnt_q == 3'd0) ? cin_q : slice_carry_q;

    prefix_adder_8b u_adder (
        .a_i    (a_q[BYTE_W-1:0]),
        .b_i    (b_q[BYTE_W-1:0]),
        .cin_i  (slice_cin),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            rr_q          <= 1'b0;
            cnt_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            cin_q         <= 1'b0;
            id_q          <= 1'b0;
            slice_carry_q <= 1'b0;
            sum_q         <= '0;
            cout_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (|req_valid_i) begin
                        a_q   <= winner ? op_a1_i : op_a0_i;
                        b_q   <= winner ? op_b1_i : op_b0_i;
                        cin_q <= carry_i[winner];
                        id_q  <= winner;
                        rr_q  <= ~winner;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    a_q           <= a_q >> BYTE_W;
                    b_q           <= b_q >> BYTE_W;
                    // Slices enter at the top; after NUM_BYTES cycles the
                    // first slice has reached bits [7:0].
                    sum_q         <= {slice_sum, sum_q[W-1:BYTE_W]};
                    slice_carry_q <= slice_cout;
                    cnt_q         <= cnt_q + 3'd1;
                    if (cnt_q == LAST) cout_q <= slice_cout;
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o = rst_i ? '0 : ready;
    assign rsp_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign rsp_id_o    = id_q;
    assign sum_o       = sum_q;
    assign carry_o     = cout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_add_scheduler.sv
// tb_serial_add_scheduler
//   Self-checking bench for serial_add_scheduler (NUM_BYTES = 4).
module tb_serial_add_scheduler;
    import serial_add_pkg::*;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk_i;
    logic         rst_i;
    logic [1:0]   req_valid_i;
    logic [1:0]   req_ready_o;
    logic [W-1:0] op_a0_i, op_b0_i, op_a1_i, op_b1_i;
    logic [1:0]   carry_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic         rsp_id_o;
    logic [W-1:0] sum_o;
    logic         carry_o;
    logic         busy_o;
    state_t       dbg_state_o;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;
    logic model_rr = 1'b0;

    serial_add_scheduler #(.NUM_BYTES(NB)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .op_a0_i     (op_a0_i),
        .op_b0_i     (op_b0_i),
        .op_a1_i     (op_a1_i),
        .op_b1_i     (op_b1_i),
        .carry_i     (carry_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_id_o    (rsp_id_o),
        .sum_o       (sum_o),
        .carry_o     (carry_o),
        .busy_o      (busy_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i)
        if (!rst_i && rsp_valid_o && rsp_ready_i) hs_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain (W+1)-bit arithmetic.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // ---------------- driver: one full transaction ----------------
    task automatic do_txn(input logic [1:0] vld,
                          input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1,
                          input logic [1:0] cin, input int stall,
                          input logic eid, input logic [W-1:0] esum, input logic ecout);
        int lat;
        int hs0;
        req_valid_i = vld;
        op_a0_i = a0; op_b0_i = b0; op_a1_i = a1; op_b1_i = b1;
        carry_i = cin;
        rsp_ready_i = (stall == 0);
        #1;
        check("ready_idle", req_ready_o, eid ? 2'b10 : 2'b01);
        check("busy_idle", busy_o, 1'b0);
        hs0 = hs_cnt;
        tick;
        // Operands may change freely after the transfer.
        req_valid_i = 2'b00;
        op_a0_i = $urandom(); op_b0_i = $urandom();
        op_a1_i = $urandom(); op_b1_i = $urandom();
        carry_i = 2'($urandom());
        lat = 1;
        while (!rsp_valid_o && lat <= 3 * NB) begin
            check("run_ready_busy", {busy_o, req_ready_o}, 3'b100);
            tick;
            lat++;
        end
        check("latency", lat, NB + 1);
        check("rsp_valid", rsp_valid_o, 1'b1);
        check("sum", sum_o, esum);
        check("carry_out", carry_o, ecout);
        check("rsp_id", rsp_id_o, eid);
        for (int s = 0; s < stall; s++) begin
            tick;
            check("stall_valid", rsp_valid_o, 1'b1);
            check("stall_sum", sum_o, esum);
            check("stall_carry", carry_o, ecout);
            check("stall_id", rsp_id_o, eid);
            check("stall_ready", req_ready_o, 2'b00);
        end
        rsp_ready_i = 1'b1;
        tick;
        check("post_hs_valid", rsp_valid_o, 1'b0);
        check("post_hs_busy", busy_o, 1'b0);
        check("handshakes", hs_cnt - hs0, 1);
        model_rr = ~eid;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]   vld;
        logic [W-1:0] a0, b0, a1, b1;
        logic [1:0]   cin;
        int           stall;
        logic         eid;
        logic [W-1:0] esum;
        logic         ecout;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [1:0]   vld;
        logic [W-1:0] a0, b0, a1, b1;
        logic [1:0]   cin;
        logic         w;
        logic [W:0]   exp;
        int           vcount;

        tbl[0] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h12345678, 32'h11111111, 2'b10, 0, 1'b0, 32'h00000000, 1'b1};
        tbl[1] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h12345678, 32'h11111111, 2'b10, 0, 1'b1, 32'h2345678A, 1'b0};
        tbl[2] = '{2'b11, 32'h80000000, 32'h80000000, 32'h00000003, 32'h00000004, 2'b00, 3, 1'b0, 32'h00000000, 1'b1};
        tbl[3] = '{2'b10, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 2'b10, 1, 1'b1, 32'h00000000, 1'b1};
        tbl[4] = '{2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 32'h00000000, 2'b01, 0, 1'b0, 32'hFFFFFFFF, 1'b0};
        tbl[5] = '{2'b11, 32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'h21524110, 2'b10, 2, 1'b1, 32'h00000000, 1'b1};

        // Reset with both requesters valid: ready must stay forced low.
        rst_i = 1'b1;
        req_valid_i = 2'b11;
        op_a0_i = '0; op_b0_i = '0; op_a1_i = '0; op_b1_i = '0;
        carry_i = 2'b00;
        rsp_ready_i = 1'b1;
        tick;
        tick;
        check("rst_ready", req_ready_o, 2'b00);
        check("rst_busy", busy_o, 1'b0);
        check("rst_valid", rsp_valid_o, 1'b0);
        check("rst_sum", sum_o, '0);
        check("rst_carry", carry_o, 1'b0);
        check("rst_id", rsp_id_o, 1'b0);
        check("rst_state", dbg_state_o, IDLE);
        rst_i = 1'b0;
        req_valid_i = 2'b00;

        // Table: directed sums, alternation from reset, DONE stall.
        for (int i = 0; i < 6; i++)
            do_txn(tbl[i].vld, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1,
                   tbl[i].cin, tbl[i].stall, tbl[i].eid, tbl[i].esum, tbl[i].ecout);

        // Reset pulse during the second RUN cycle abandons the operation.
        req_valid_i = 2'b10;
        op_a1_i = 32'h00000005; op_b1_i = 32'h00000006; carry_i = 2'b00;
        tick;                       // transfer; now in first RUN cycle
        req_valid_i = 2'b00;
        tick;                       // second RUN cycle
        check("pre_rst_busy", busy_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check("rst_run_ready", req_ready_o, 2'b00);
        tick;
        rst_i = 1'b0;
        check("post_rst_busy", busy_o, 1'b0);
        check("post_rst_state", dbg_state_o, IDLE);
        check("post_rst_sum", sum_o, '0);
        vcount = 0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid_o) vcount++;
            tick;
        end
        check("no_rsp_after_rst", vcount, 0);
        model_rr = 1'b0;
        do_txn(2'b11, 32'hCAFEF00D, 32'h01010101, 32'h0, 32'h0, 2'b01, 0,
               1'b0, 32'hCBFFF10F, 1'b0);

        // Randomized traffic against the arithmetic / round-robin model.
        for (int n = 0; n < 40; n++) begin
            vld = 2'($urandom_range(1, 3));
            a0 = ($urandom_range(0, 3) == 0) ? {W{1'b1}} : W'($urandom());
            b0 = W'($urandom());
            a1 = ($urandom_range(0, 3) == 0) ? {W{1'b1}} : W'($urandom());
            b1 = ($urandom_range(0, 3) == 0) ? W'(1) : W'($urandom());
            cin = 2'($urandom());
            w = (vld == 2'b11) ? model_rr : vld[1];
            exp = w ? ref_add(a1, b1, cin[1]) : ref_add(a0, b0, cin[0]);
            do_txn(vld, a0, b0, a1, b1, cin, $urandom_range(0, 2),
                   w, exp[W-1:0], exp[W]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
